// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit
//   Iterative multiply / divide engine for the EX stage. It computes
//   MULT/MULTU/MADD/MADDU/MSUB/MSUBU/DIV/DIVU into a 2*DATA_W {HI,LO} result.
//   Multiplies retire MUL_BITS multiplier bits per cycle. Divides use a
//   restoring radix-2 loop that produces one quotient bit per cycle.
//   Signed operands are turned into unsigned magnitudes at accept time, and
//   the signs are applied once in the FIX state.
//
// Ports
//   clk, rst      clock, synchronous active-high reset
//   start_i       request, sampled only while idle
//   op_i          000 MULT 001 MULTU 010 MADD 011 MADDU
//                 100 MSUB 101 MSUBU 110 DIV  111 DIVU
//   opdata1_i     multiplicand / dividend
//   opdata2_i     multiplier / divisor
//   hilo_i        {HI,LO} accumulate source, sampled with start_i
//   annul_i       abort the current operation (pipeline flush)
//   busy_o        high in every state except IDLE
//   ready_o       one-cycle pulse, result_o valid
//   result_o      registered {HI,LO}, held until the next result write
//   div_zero_o    set with a divide-by-zero result, cleared on next accept

module ex_muldiv_unit #(
   parameter int DATA_W   = 32,
   parameter int MUL_BITS = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start_i,
   input  logic [2:0]            op_i,
   input  logic [DATA_W-1:0]     opdata1_i,
   input  logic [DATA_W-1:0]     opdata2_i,
   input  logic [2*DATA_W-1:0]   hilo_i,
   input  logic                  annul_i,
   output logic                  busy_o,
   output logic                  ready_o,
   output logic [2*DATA_W-1:0]   result_o,
   output logic                  div_zero_o
);

   localparam int MUL_STEPS = DATA_W / MUL_BITS;
   localparam int CNT_W     = $clog2(DATA_W + 1);
   localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(MUL_STEPS - 1);
   localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DATA_W - 1);

   typedef enum logic [2:0] {IDLE, MUL, DIV, FIX, DONE} state_t;

   state_t                 state_reg, state_next;
   logic [2:0]             op_reg;
   logic                   s1_reg, s2_reg;
   // Multiplicand magnitude for multiplies, divisor magnitude for divides.
   logic [DATA_W-1:0]      opb_reg;
   logic [2*DATA_W-1:0]    hilo_reg;
   // Multiply: {partial product high, remaining multiplier bits / product low}.
   // Divide:   {partial remainder, remaining dividend bits / quotient}.
   logic [2*DATA_W-1:0]    acc_reg;
   logic [CNT_W-1:0]       cnt_reg;
   logic [2*DATA_W-1:0]    result_reg;
   logic                   div_zero_reg;

   // ---------------- accept-time decode ----------------
   logic                   signed_in, div_in, accept;
   logic [DATA_W-1:0]      mag1_in, mag2_in;

   assign signed_in = ~op_i[0];
   assign div_in    = op_i[2] & op_i[1];
   assign accept    = start_i & ~annul_i;
   assign mag1_in   = (signed_in && opdata1_i[DATA_W-1]) ? -opdata1_i : opdata1_i;
   assign mag2_in   = (signed_in && opdata2_i[DATA_W-1]) ? -opdata2_i : opdata2_i;

   // ---------------- multiply step ----------------
   // The multiplier sits in the low half of acc_reg and is consumed LSB first.
   // Each step adds opb * digit to the high half, then shifts the whole
   // accumulator right by MUL_BITS. The sum fits in DATA_W+MUL_BITS bits.
   logic [MUL_BITS-1:0]        digit;
   logic [DATA_W+MUL_BITS-1:0] pp, mul_sum;
   logic [2*DATA_W-1:0]        mul_step;

   assign digit   = acc_reg[MUL_BITS-1:0];
   assign pp      = {{MUL_BITS{1'b0}}, opb_reg} * {{DATA_W{1'b0}}, digit};
   assign mul_sum = {{MUL_BITS{1'b0}}, acc_reg[2*DATA_W-1:DATA_W]} + pp;

   generate
      if (MUL_BITS < DATA_W) begin : g_mul_shift
         assign mul_step = {mul_sum, acc_reg[DATA_W-1:MUL_BITS]};
      end else begin : g_mul_single
         assign mul_step = mul_sum;
      end
   endgenerate

   // ---------------- divide step ----------------
   // Shift the next dividend bit into the remainder and try a subtraction.
   // The remainder is always below the divisor, so a successful trial fits
   // in DATA_W bits.
   logic [DATA_W:0]        rem_sh, trial;
   logic [2*DATA_W-1:0]    div_step;

   assign rem_sh   = acc_reg[2*DATA_W-1:DATA_W-1];
   assign trial    = rem_sh - {1'b0, opb_reg};
   assign div_step = trial[DATA_W] ? {rem_sh[DATA_W-1:0], acc_reg[DATA_W-2:0], 1'b0}
                                   : {trial[DATA_W-1:0],  acc_reg[DATA_W-2:0], 1'b1};

   // ---------------- sign fix-up and accumulate ----------------
   logic                   op_signed;
   logic [2*DATA_W-1:0]    prod_fix, fix_result;
   logic [DATA_W-1:0]      quo_fix, rem_fix;

   assign op_signed = ~op_reg[0];
   assign prod_fix  = (op_signed && (s1_reg ^ s2_reg)) ? -acc_reg : acc_reg;
   assign quo_fix   = (op_signed && (s1_reg ^ s2_reg)) ? -acc_reg[DATA_W-1:0]
                                                       :  acc_reg[DATA_W-1:0];
   assign rem_fix   = (op_signed && s1_reg) ? -acc_reg[2*DATA_W-1:DATA_W]
                                            :  acc_reg[2*DATA_W-1:DATA_W];

   always_comb begin
      fix_result = prod_fix;
      case (op_reg[2:1])
         2'b00:   fix_result = prod_fix;
         2'b01:   fix_result = hilo_reg + prod_fix;
         2'b10:   fix_result = hilo_reg - prod_fix;
         default: fix_result = {rem_fix, quo_fix};
      endcase
   end

   // ---------------- FSM ----------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      busy_o     = 1'b1;
      ready_o    = 1'b0;
      case (state_reg)
         IDLE: begin
            busy_o = 1'b0;
            if (accept) begin
               if (!div_in)                 state_next = MUL;
               else if (opdata2_i == '0)    state_next = DONE;
               else                         state_next = DIV;
            end
         end
         MUL:  if (cnt_reg == MUL_LAST) state_next = FIX;
         DIV:  if (cnt_reg == DIV_LAST) state_next = FIX;
         FIX:  state_next = DONE;
         DONE: begin
            ready_o    = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
      // A flush drops whatever is in flight. While idle, annul_i simply
      // blocks the accept.
      if (annul_i && state_reg != IDLE) state_next = IDLE;
   end

   // ---------------- datapath ----------------
   always_ff @(posedge clk) begin
      if (rst) begin
         op_reg       <= '0;
         s1_reg       <= 1'b0;
         s2_reg       <= 1'b0;
         opb_reg      <= '0;
         hilo_reg     <= '0;
         acc_reg      <= '0;
         cnt_reg      <= '0;
         result_reg   <= '0;
         div_zero_reg <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (accept) begin
                  op_reg       <= op_i;
                  s1_reg       <= signed_in & opdata1_i[DATA_W-1];
                  s2_reg       <= signed_in & opdata2_i[DATA_W-1];
                  hilo_reg     <= hilo_i;
                  cnt_reg      <= '0;
                  div_zero_reg <= 1'b0;
                  if (div_in) begin
                     opb_reg <= mag2_in;
                     acc_reg <= {{DATA_W{1'b0}}, mag1_in};
                     // A zero divisor skips straight to DONE with a zero result.
                     if (opdata2_i == '0) begin
                        result_reg   <= '0;
                        div_zero_reg <= 1'b1;
                     end
                  end else begin
                     opb_reg <= mag1_in;
                     acc_reg <= {{DATA_W{1'b0}}, mag2_in};
                  end
               end
            end
            MUL: begin
               acc_reg <= mul_step;
               cnt_reg <= cnt_reg + CNT_W'(1);
            end
            DIV: begin
               acc_reg <= div_step;
               cnt_reg <= cnt_reg + CNT_W'(1);
            end
            FIX: begin
               if (!annul_i) result_reg <= fix_result;
            end
            default: ;
         endcase
      end
   end

   assign result_o   = result_reg;
   assign div_zero_o = div_zero_reg;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Self-checking bench for ex_muldiv_unit (DATA_W=32, MUL_BITS=2).
// A high-level model tracks the expected result, latency and busy/ready,
// and a compare process checks it every cycle. Directed vectors also check
// hand-computed results and latencies.

module tb_ex_muldiv_unit;

   localparam logic [2:0] OP_MULT  = 3'd0, OP_MULTU = 3'd1, OP_MADD = 3'd2, OP_MADDU = 3'd3,
                          OP_MSUB  = 3'd4, OP_MSUBU = 3'd5, OP_DIV  = 3'd6, OP_DIVU  = 3'd7;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start_i = 1'b0;
   logic        annul_i = 1'b0;
   logic [2:0]  op_i = 3'd0;
   logic [31:0] opdata1_i = '0;
   logic [31:0] opdata2_i = '0;
   logic [63:0] hilo_i = '0;
   logic        busy_o, ready_o, div_zero_o;
   logic [63:0] result_o;

   ex_muldiv_unit #(.DATA_W(32), .MUL_BITS(2)) dut (
      .clk        (clk),
      .rst        (rst),
      .start_i    (start_i),
      .op_i       (op_i),
      .opdata1_i  (opdata1_i),
      .opdata2_i  (opdata2_i),
      .hilo_i     (hilo_i),
      .annul_i    (annul_i),
      .busy_o     (busy_o),
      .ready_o    (ready_o),
      .result_o   (result_o),
      .div_zero_o (div_zero_o)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic logic [63:0] model_calc(input logic [2:0] op, input logic [31:0] a,
                                              input logic [31:0] b, input logic [63:0] h);
      logic signed [63:0] sa, sb, q, r;
      logic [63:0] ua, ub;
      sa = {{32{a[31]}}, a};
      sb = {{32{b[31]}}, b};
      ua = {32'd0, a};
      ub = {32'd0, b};
      case (op)
         OP_MULT:  return sa * sb;
         OP_MULTU: return ua * ub;
         OP_MADD:  return h + sa * sb;
         OP_MADDU: return h + ua * ub;
         OP_MSUB:  return h - sa * sb;
         OP_MSUBU: return h - ua * ub;
         OP_DIV: begin
            if (b == 0) return 64'd0;
            q = sa / sb;
            r = sa % sb;
            return {r[31:0], q[31:0]};
         end
         default: begin
            if (b == 0) return 64'd0;
            return {a % b, a / b};
         end
      endcase
   endfunction

   function automatic int model_lat(input logic [2:0] op, input logic [31:0] b);
      if (op[2:1] == 2'b11) return (b == 0) ? 1 : 34;
      return 18;
   endfunction

   // m_left: cycles still busy, counting the ready cycle itself (0 = idle).
   int          m_left = 0;
   logic [63:0] m_result = '0;
   logic [63:0] m_pend = '0;
   logic        m_dz = 1'b0;
   bit          checking = 1'b0;

   always @(posedge clk) begin
      if (rst) begin
         m_left   <= 0;
         m_result <= '0;
         m_dz     <= 1'b0;
      end else if (m_left > 0) begin
         if (annul_i) begin
            m_left <= 0;
         end else begin
            m_left <= m_left - 1;
            if (m_left == 2) m_result <= m_pend;
         end
      end else if (start_i && !annul_i) begin
         m_left <= model_lat(op_i, opdata2_i);
         m_pend <= model_calc(op_i, opdata1_i, opdata2_i, hilo_i);
         if (op_i[2:1] == 2'b11 && opdata2_i == 32'd0) begin
            m_result <= '0;
            m_dz     <= 1'b1;
         end else begin
            m_dz <= 1'b0;
         end
      end
   end

   always @(negedge clk) begin
      if (checking) begin
         chk("cyc_busy",   64'(busy_o),     64'(m_left > 0));
         chk("cyc_ready",  64'(ready_o),    64'(m_left == 1));
         chk("cyc_result", result_o,        m_result);
         chk("cyc_dz",     64'(div_zero_o), 64'(m_dz));
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic start_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [63:0] h);
      op_i      = op;
      opdata1_i = a;
      opdata2_i = b;
      hilo_i    = h;
      start_i   = 1'b1;
   endtask

   // Waits for ready_o. The first negedge sampled is in cycle first_cyc.
   task automatic wait_ready(input int first_cyc, input logic [63:0] exp_res, input logic exp_dz,
                             input int exp_lat, input string name);
      int cyc;
      bit seen;
      cyc  = first_cyc;
      seen = 1'b0;
      while (cyc <= 200 && !seen) begin
         @(negedge clk);
         if (ready_o) seen = 1'b1;
         else cyc++;
      end
      n_checks++;
      if (!seen) begin
         n_fail++;
         $display("FAIL %s_timeout: ready_o never seen, expected in cycle %0d", name, exp_lat);
      end else begin
         chk({name, "_lat"}, 64'(cyc), 64'(exp_lat));
         chk({name, "_res"}, result_o, exp_res);
         chk({name, "_dz"},  64'(div_zero_o), 64'(exp_dz));
      end
      $display("%s: ready cycle %0d result=%h div_zero=%0b", name, cyc, result_o, div_zero_o);
   endtask

   task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] h, input logic [63:0] exp_res, input logic exp_dz,
                         input int exp_lat, input string name);
      @(posedge clk); #1;
      start_op(op, a, b, h);
      @(posedge clk); #1;
      start_i = 1'b0;
      wait_ready(1, exp_res, exp_dz, exp_lat, name);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      // Hand-computed pins for the model itself.
      chk("model_mult",  model_calc(OP_MULT, 32'hFFFFFFFD, 32'd5, 64'd0), 64'hFFFFFFFF_FFFFFFF1);
      chk("model_div",   model_calc(OP_DIV, 32'hFFFFFFF9, 32'd2, 64'd0),  64'hFFFFFFFF_FFFFFFFD);
      chk("model_msubu", model_calc(OP_MSUBU, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'd5),
          64'h00000002_00000004);

      @(posedge clk); #1;
      checking = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("reset_busy",   64'(busy_o), 64'd0);
      chk("reset_ready",  64'(ready_o), 64'd0);
      chk("reset_result", result_o, 64'd0);
      chk("reset_dz",     64'(div_zero_o), 64'd0);

      run_op(OP_MULT,  32'hFFFFFFFD, 32'd5, 64'd0, 64'hFFFFFFFF_FFFFFFF1, 1'b0, 18, "mult_neg3x5");
      run_op(OP_MADDU, 32'hFFFFFFFF, 32'd2, 64'h00000001_00000000,
             64'h00000002_FFFFFFFE, 1'b0, 18, "maddu");
      run_op(OP_MSUB,  32'd3, 32'd4, 64'd0, 64'hFFFFFFFF_FFFFFFF4, 1'b0, 18, "msub");
      run_op(OP_DIV,   32'hFFFFFFF9, 32'd2, 64'd0, 64'hFFFFFFFF_FFFFFFFD, 1'b0, 34, "div_neg7by2");
      run_op(OP_DIVU,  32'h1234, 32'd0, 64'd0, 64'd0, 1'b1, 1, "divu_by0");
      run_op(OP_MULTU, 32'd2, 32'd3, 64'd0, 64'd6, 1'b0, 18, "multu_2x3");
      run_op(OP_MULT,  32'h80000000, 32'h80000000, 64'd0, 64'h40000000_00000000, 1'b0, 18, "mult_minmin");
      run_op(OP_DIV,   32'h80000000, 32'hFFFFFFFF, 64'd0, 64'h00000000_80000000, 1'b0, 34, "div_min_m1");
      run_op(OP_DIVU,  32'd100, 32'd7, 64'd0, 64'h00000002_0000000E, 1'b0, 34, "divu_100by7");
      run_op(OP_MSUBU, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'd5, 64'h00000002_00000004, 1'b0, 18, "msubu");
      run_op(OP_MADD,  32'hFFFFFFFE, 32'hFFFFFFFD, 64'h10, 64'h16, 1'b0, 18, "madd");
      run_op(OP_DIV,   32'd7, 32'hFFFFFFFE, 64'd0, 64'h00000001_FFFFFFFD, 1'b0, 34, "div_7bym2");
      run_op(OP_DIV,   32'hFFFFFFF8, 32'hFFFFFFFD, 64'd0, 64'hFFFFFFFE_00000002, 1'b0, 34, "div_m8bym3");

      // Annul a divide in cycle 10, then start a new multiply in cycle 11.
      @(posedge clk); #1;
      start_op(OP_DIVU, 32'd100, 32'd7, 64'd0);
      @(posedge clk); #1;
      start_i = 1'b0;
      repeat (9) @(posedge clk);
      #1 annul_i = 1'b1;
      @(posedge clk); #1;
      annul_i = 1'b0;
      start_op(OP_MULT, 32'd7, 32'hFFFFFFFA, 64'd0);
      @(negedge clk);
      chk("annul_busy",   64'(busy_o), 64'd0);
      chk("annul_ready",  64'(ready_o), 64'd0);
      chk("annul_result", result_o, 64'hFFFFFFFE_00000002);
      $display("annul: divide dropped in cycle 10, result=%h", result_o);
      @(posedge clk); #1;
      start_i = 1'b0;
      wait_ready(1, 64'hFFFFFFFF_FFFFFFD6, 1'b0, 18, "mult_after_annul");

      // start_i pulsed while busy must be ignored.
      @(posedge clk); #1;
      start_op(OP_MULT, 32'd3, 32'd5, 64'd0);
      @(posedge clk); #1;
      start_i = 1'b0;
      repeat (3) @(posedge clk);
      #1 start_op(OP_DIVU, 32'd99, 32'd9, 64'd0);
      @(posedge clk); #1;
      start_i = 1'b0;
      wait_ready(5, 64'd15, 1'b0, 18, "mult_ignore_start");

      // Reset asserted in cycle 5 of a multiply.
      @(posedge clk); #1;
      start_op(OP_MULT, 32'd9, 32'd9, 64'd0);
      @(posedge clk); #1;
      start_i = 1'b0;
      repeat (4) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("midrst_busy",   64'(busy_o), 64'd0);
      chk("midrst_ready",  64'(ready_o), 64'd0);
      chk("midrst_result", result_o, 64'd0);
      chk("midrst_dz",     64'(div_zero_o), 64'd0);
      $display("reset mid-mult: busy=%0b result=%h", busy_o, result_o);
      repeat (20) @(posedge clk);

      // start and annul together while idle: the start is dropped.
      #1 start_op(OP_MULTU, 32'd2, 32'd2, 64'd0);
      annul_i = 1'b1;
      @(posedge clk); #1;
      start_i = 1'b0;
      annul_i = 1'b0;
      @(negedge clk);
      chk("start_annul_busy", 64'(busy_o), 64'd0);
      repeat (20) @(posedge clk);
      @(negedge clk);
      chk("start_annul_result", result_o, 64'd0);
      $display("start+annul idle: busy=%0b result=%h", busy_o, result_o);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
